// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-memory completer.
//   ADDR_W / DATA_W : default bus widths
//   apb_slv_state_e : completer FSM states
//   addr_err()      : bad-address decode (misaligned or outside the word window)
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_slv_state_e;

    // An address is bad when it is not word aligned or its word index
    // lands beyond the last implemented word.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// DEPTH x DATA_W word store.
//   clk, rst_n : clock, async active-low clear of every word
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module apb_slave_mem_array
    import apb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer in front of a word-addressed register memory.
// Each access holds PREADY low for WAIT_CYCLES access cycles, then completes;
// misaligned or out-of-window addresses complete with PSLVERR=1 and no effect.
//   clk, PRESETn                     : bus clock, async active-low reset
//   PSEL1, PENABLE, PWRITE, PADDR, PWDATA : requester side of the bus
//   PRDATA, PREADY, PSLVERR          : registered completer responses
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = apb_pkg::ADDR_W,
    parameter int DATA_W      = apb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              PRESETn,
    input  logic              PSEL1,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int         IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    // Setup-phase snapshot; the access phase never looks at PADDR/PWDATA again.
    typedef struct packed {
        logic              write;
        logic [IW-1:0]     idx;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } req_t;

    apb_slv_state_e    state;
    req_t              req;
    logic [3:0]        cnt;
    logic              setup;
    logic              err_now;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;

    assign setup   = PSEL1 && !PENABLE;
    assign err_now = addr_err(PADDR, DEPTH);

    // Zero-wait reads respond straight from the setup-phase address.
    assign rd_idx = (state == IDLE) ? PADDR[IW+1:2] : req.idx;

    // The write commits on the completion edge only, so an abort or reset
    // before that edge leaves memory untouched.
    assign mem_we = (state == READY) && PSEL1 && PENABLE && req.write && !req.err;

    apb_slave_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_array (
        .clk   (clk),
        .rst_n (PRESETn),
        .we    (mem_we),
        .waddr (req.idx),
        .wdata (req.wdata),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            req     <= '0;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // PENABLE without a preceding setup phase falls through here.
                    if (setup) begin
                        req <= '{write: PWRITE, idx: PADDR[IW+1:2],
                                 wdata: PWDATA, err: err_now};
                        if (WC == 4'd0) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_now;
                            PRDATA  <= (!PWRITE && !err_now) ? rd_data : '0;
                        end else begin
                            cnt   <= WC;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= req.err;
                            PRDATA  <= (!req.write && !req.err) ? rd_data : '0;
                        end
                    end
                end
                READY: begin
                    // Completion edge or abort: either way the response is one cycle.
                    if (!PSEL1 || PENABLE) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench: two completers (2 wait states and 0 wait states) on separate buses.
// The driver pushes the expected response of each transfer; a monitor per bus
// pops and compares whenever PREADY is seen.
module tb_apb_slave_mem;

    localparam int DEPTH = 64;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] mem_m [2][DEPTH];
    exp_t        expq  [2][$];
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clk(clk), .PRESETn(rst_n), .PSEL1(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .PRESETn(rst_n), .PSEL1(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    function automatic int wc(input int b);
        return (b == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) mem_m[b][i] = '0;
    endtask

    // Monitors: latency counted in access cycles, response popped on PREADY.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int   acc = 0;
        exp_t e;
        always @(negedge clk) begin
            if (!rst_n || !psel[g] || !penable[g]) acc = 0;
            else acc = acc + 1;
            if (pslverr[g]) chk($sformatf("bus%0d pslverr_needs_pready", g), 32'(pready[g]), 32'd1);
            if (pready[g]) begin
                if (expq[g].size() == 0) begin
                    total++;
                    $display("FAIL bus%0d unexpected_pready: got 1 expected 0", g);
                end else begin
                    e = expq[g].pop_front();
                    chk($sformatf("bus%0d pslverr", g), 32'(pslverr[g]), 32'(e.err));
                    chk($sformatf("bus%0d prdata", g), prdata[g], e.rdata);
                    chk($sformatf("bus%0d latency", g), 32'(acc), 32'(wc(g) + 1));
                end
            end
        end
    end

    // abort_at >= 0: at that access cycle drop PSEL1 (or pulse reset if rst_abort).
    task automatic xfer(input int b, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int abort_at, input bit rst_abort);
        exp_t        e;
        bit          err;
        int          idx;
        int          cyc;
        logic [31:0] widx;
        widx = a >> 2;
        idx  = int'(widx);
        err  = (a[1:0] != 2'b00) || (widx >= DEPTH);
        if (abort_at < 0) begin
            e.err   = err;
            e.rdata = (!wr && !err) ? mem_m[b][idx] : 32'd0;
            expq[b].push_back(e);
            if (wr && !err) mem_m[b][idx] = d;
        end
        psel[b] = 1'b1; penable[b] = 1'b0; pwrite[b] = wr; paddr[b] = a; pwdata[b] = d;
        @(posedge clk); #1;
        // Bus values after setup must be ignored by the completer.
        penable[b] = 1'b1; paddr[b] = $urandom; pwdata[b] = $urandom;
        cyc = 0;
        while (1) begin
            if (pready[b]) begin
                @(posedge clk); #1;
                break;
            end
            if (cyc == abort_at) begin
                if (rst_abort) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_abort pready", 32'(pready[b]), 32'd0);
                    chk("rst_abort pslverr", 32'(pslverr[b]), 32'd0);
                    chk("rst_abort prdata", prdata[b], 32'd0);
                    clear_model();
                    psel[b] = 1'b0; penable[b] = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end else begin
                    psel[b] = 1'b0; penable[b] = 1'b0;
                    @(posedge clk); #1;
                end
                break;
            end
            if (cyc > 40) begin
                total++;
                $display("FAIL bus%0d timeout: got no PREADY expected PREADY within %0d cycles", b, wc(b) + 1);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        psel[b] = 1'b0; penable[b] = 1'b0;
    endtask

    initial begin
        int          b;
        int          widx;
        logic [31:0] a;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0; pwdata[i] = 0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bus%0d reset pready", i), 32'(pready[i]), 32'd0);
            chk($sformatf("bus%0d reset pslverr", i), 32'(pslverr[i]), 32'd0);
            chk($sformatf("bus%0d reset prdata", i), prdata[i], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed, 2 wait states.
        xfer(0, 0, 32'h10, 32'h0, -1, 0);
        xfer(0, 1, 32'h04, 32'hDEADBEEF, -1, 0);
        xfer(0, 0, 32'h04, 32'h0, -1, 0);
        xfer(0, 1, 32'h102, 32'h12345678, -1, 0);
        xfer(0, 0, 32'h100, 32'h0, -1, 0);
        xfer(0, 0, 32'h00, 32'h0, -1, 0);

        // Zero wait states, back-to-back with no idle cycle.
        xfer(1, 1, 32'h08, 32'h11112222, -1, 0);
        xfer(1, 1, 32'h0C, 32'h33334444, -1, 0);
        xfer(1, 0, 32'h08, 32'h0, -1, 0);
        xfer(1, 0, 32'h0C, 32'h0, -1, 0);

        // Reset in the middle of a waited write.
        xfer(0, 1, 32'h20, 32'hA5A5A5A5, 0, 1);
        xfer(0, 0, 32'h20, 32'h0, -1, 0);
        xfer(1, 0, 32'h08, 32'h0, -1, 0);

        // PSEL1 dropped during the wait.
        xfer(0, 1, 32'h24, 32'hCAFEF00D, 1, 0);
        xfer(0, 0, 32'h24, 32'h0, -1, 0);
        xfer(0, 1, 32'h28, 32'h0BADF00D, -1, 0);
        xfer(0, 0, 32'h28, 32'h0, -1, 0);

        // PENABLE without a setup phase must not start anything.
        psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h28;
        repeat (3) @(posedge clk);
        #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            b    = int'($urandom_range(0, 1));
            widx = int'($urandom_range(0, DEPTH + 3));
            a    = 32'(widx) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (b == 0 && $urandom_range(0, 9) == 0)
                xfer(0, 1'($urandom), a, $urandom, int'($urandom_range(0, 1)), 0);
            else
                xfer(b, 1'($urandom), a, $urandom, -1, 0);
        end

        for (int i = 0; i < 50 && (expq[0].size() + expq[1].size()) != 0; i++) @(posedge clk);
        if ((expq[0].size() + expq[1].size()) != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", expq[0].size() + expq[1].size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer: the responder end of the `APB_intf` bus (consumes PSEL1/PENABLE/PWRITE/PADDR/PWDATA; drives PRDATA/PREADY/PSLVERR).
- Word-addressed register memory with a fixed number of wait states per access, plus PSLVERR on bad addresses.
- Serves as the DUT behind the existing APB driver/monitors and satisfies the bus-side protocol assertions.

Parameters:
- DEPTH, 64, number of 32-bit words; the address window is bytes 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 2, access-phase cycles with PREADY low before PREADY rises (0..15).
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.

Ports:
- clk  input  1  bus clock; all sampling on the rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- PSEL1  input  1  slave select.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data; valid while PREADY=1 on a read.
- PREADY  output  1  transfer-complete, registered.
- PSLVERR  output  1  error flag; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM goes to IDLE, wait counter = 0, all memory words = 0.
  - Reset deasserts synchronously to clk.
  - Reset mid-transfer abandons the transfer; no memory write occurs.
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On an edge sampling PSEL1=1 and PENABLE=0 (setup phase), latch PWRITE, PADDR, PWDATA and decode the error.
  - err = (PADDR[1:0] != 0) OR (PADDR >> 2 >= DEPTH).
  - If WAIT_CYCLES=0: go to READY, register PREADY=1, PSLVERR=err. PRDATA = mem[idx] for a read with no error, else 0.
  - Otherwise: load counter = WAIT_CYCLES and go to WAIT.
- WAIT:
  - On each edge with PSEL1=1 and PENABLE=1, decrement the counter.
  - When the counter reaches 1 at an edge, go to READY and register PREADY/PSLVERR/PRDATA as above.
  - Result: PREADY is high in access cycle WAIT_CYCLES+1.
- READY (the completion edge is the one sampling PSEL1=1, PENABLE=1, PREADY=1):
  - If write and not err: mem[idx] <= latched PWDATA.
  - PREADY, PSLVERR and PRDATA return to 0; go to IDLE.
- Back-to-back transfers: a new setup phase presented in the cycle after completion is accepted normally from IDLE.
- Protocol violations:
  - PSEL1=0 in WAIT or READY aborts the transfer: go to IDLE, no write, outputs cleared next edge.
  - PENABLE=1 seen in IDLE with no preceding setup is ignored.
- Write data and address come only from the latched setup-phase values; changes during access are not used.
- PREADY is never high outside the access phase, and is high for exactly one cycle per transfer.
- PSLVERR=1 only together with PREADY=1.
- PRDATA=0 for writes and for errored reads.

Decomposition:
- Package apb_pkg holds:
  - ADDR_W and DATA_W localparams;
  - typedef enum apb_slv_state_e {IDLE, WAIT, READY};
  - function addr_err(addr, depth).
- One sub-module, apb_slave_mem_array: DEPTH x DATA_W flop array with async clear, one synchronous write port and one combinational read port.
- The FSM, wait counter and output registers stay in apb_slave_mem.

Test Plan:
- Reset, then read 0x10 with WAIT_CYCLES=2 -> PREADY low for 2 access cycles and high in the 3rd, PRDATA=0, PSLVERR=0.
- Write 0xDEADBEEF to 0x04, then read 0x04 -> PSLVERR=0 on both; the read returns PRDATA=0xDEADBEEF; PENABLE falls the cycle after PREADY.
- Write 0x12345678 to 0x102 (misaligned), then read 0x100 (idx 64 ≥ DEPTH) -> PSLVERR=1 with PREADY on both; mem[0] unchanged (read 0x00 returns 0).
- Back-to-back writes to 0x08 then 0x0C with no idle cycle, WAIT_CYCLES=0 -> PREADY high in each first access cycle; both words stored.
- Assert PRESETn=0 mid-WAIT of a write of 0xA5A5A5A5 to 0x20 -> PREADY/PSLVERR/PRDATA drop immediately; a later read of 0x20 returns 0.
- Drop PSEL1 during WAIT of a write to 0x24 -> no PREADY pulse; a subsequent read of 0x24 returns 0; the next transfer completes normally.
